serial_adder_unit: RTL and testbench

- Bit-serial adder for the ALU datapath.
- Adds two W-bit operands LSB-first using one full-adder cell, one bit per clock.
- Start/busy/done handshake with the ALU sequencer.
- Trades latency for area against the ripple combinational adder/subtractor chain.

---
 rtl/serial_alu_pkg.sv | 12 +
 rtl/serial_fa_cell.sv | 13 +
 rtl/serial_adder_unit.sv | 117 +++++++++++
 tb/tb_serial_adder_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial ALU datapath blocks.
package serial_alu_pkg;

  localparam int SERIAL_ALU_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder used as the single arithmetic cell of the serial adder.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_unit.sv
// Bit-serial W-bit adder, LSB first, one bit per clock, start/busy/done handshake.
// Optional subtract mode (iSub port) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_unit
  import serial_alu_pkg::*;
#(
  parameter int W = SERIAL_ALU_W
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStart,
  input  logic [W-1:0] iA,
  input  logic [W-1:0] iB,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         iSub,
`endif
  output logic         oBusy,
  output logic         oDone,
  output logic [W-1:0] oSum,
  output logic         oCarry
);

  // Handshake: iStart is a request sampled only in IDLE; oBusy is high for the
  // W RUN cycles; oDone pulses for one cycle with oSum/oCarry already valid.
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t state;
  state_t state_nxt;

  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-1:0]  sum_sr;
  logic [W-1:0]  sum_nxt;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          sub_q;
  logic          sub_in;
  logic          fa_s;
  logic          fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = iSub;
`else
  assign sub_in = 1'b0;
`endif

  serial_fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign sum_nxt = {fa_s, sum_sr[W-1:1]};

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    case (state)
      IDLE: if (iStart) state_nxt = RUN;
      RUN: begin
        oBusy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        oDone     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      oSum   <= '0;
      oCarry <= 1'b0;
    end else begin
      case (state)
        IDLE: if (iStart) begin
          // Subtract is A + ~B + 1: invert B on capture and seed the carry.
          a_sr   <= iA;
          b_sr   <= sub_in ? ~iB : iB;
          sum_sr <= '0;
          cnt    <= '0;
          carry  <= sub_in;
          sub_q  <= sub_in;
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_nxt;
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            oSum   <= sum_nxt;
            oCarry <= sub_q ? ~fa_cout : fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_unit.sv
// Scoreboard bench for serial_adder_unit: random and directed operations,
// latency/handshake checks, ignored starts, mid-run reset, back-to-back starts.
module tb_serial_adder_unit;

  localparam int W = 8;

  logic         iClk;
  logic         iRst;
  logic         iStart;
  logic [W-1:0] iA;
  logic [W-1:0] iB;
  logic         iSub;
  logic         oBusy;
  logic         oDone;
  logic [W-1:0] oSum;
  logic         oCarry;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W:0] exp_q[$];
  logic [W:0] held;

  serial_adder_unit #(.W(W)) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (iStart),
    .iA     (iA),
    .iB     (iB),
`ifdef SERIAL_ADDER_SUB_EN
    .iSub   (iSub),
`endif
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oSum   (oSum),
    .oCarry (oCarry)
  );

  // clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: {carry, sum} of A+B, or {borrow, A-B mod 2^W} for subtract.
  function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
    int unsigned ai;
    int unsigned bi;
    ai = a;
    bi = b;
    if (sub) ref_model = {(ai < bi) ? 1'b1 : 1'b0, W'((ai + 256 - bi) % 256)};
    else     ref_model = (W+1)'(ai + bi);
  endfunction

  // monitor: compare on oDone, otherwise outputs must hold the last result
  always @(negedge iClk) begin
    if (iRst) begin
      held = '0;
    end else if (oDone) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(oDone), 32'd0);
      end else begin
        held = exp_q.pop_front();
        check("result", 32'({oCarry, oSum}), 32'(held));
      end
    end else begin
      check("held_result", 32'({oCarry, oSum}), 32'(held));
    end
  end

  // driver: issue start, push expectation at the accepting edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    @(negedge iClk);
    iA = a; iB = b; iSub = sub; iStart = 1'b1;
    @(posedge iClk);
    exp_q.push_back(ref_model(a, b, sub));
    @(negedge iClk);
    iStart = 1'b0;
    iA = W'($urandom); iB = W'($urandom);
  endtask

  // Full operation with latency/busy checks; noise pulses iStart mid-RUN and in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input bit noise);
    int busy_n;
    int done_j;
    issue(a, b, sub);
    busy_n = oBusy ? 1 : 0;
    done_j = -1;
    for (int j = 1; j <= W + 4; j++) begin
      @(negedge iClk);
      iStart = 1'b0;
      if (noise && j == 3) begin
        iStart = 1'b1; iA = 8'hAA; iB = 8'hAA;
      end
      if (oDone) begin
        done_j = j;
        check("busy_low_in_done", 32'(oBusy), 32'd0);
        if (noise) begin
          iStart = 1'b1; iA = 8'hAA; iB = 8'hAA;
        end
        break;
      end
      if (oBusy) busy_n++;
    end
    check("done_latency", 32'(done_j), 32'(W));
    check("busy_cycles", 32'(busy_n), 32'(W));
    @(negedge iClk);
    iStart = 1'b0;
    check("done_single", 32'(oDone), 32'd0);
    check("idle_after_done", 32'(oBusy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int dones[$];
    iRst = 1'b1; iStart = 1'b0; iA = '0; iB = '0; iSub = 1'b0;
    repeat (3) @(negedge iClk);
    check("reset_busy", 32'(oBusy), 32'd0);
    check("reset_done", 32'(oDone), 32'd0);
    check("reset_sum", 32'({oCarry, oSum}), 32'd0);
    iRst = 1'b0;
    repeat (2) @(negedge iClk);

    // directed cases
    run_op(8'h35, 8'h4A, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 1'b1);
    repeat (3) @(negedge iClk);
    check("no_restart_after_ignored", 32'(oBusy), 32'd0);

    // reset during the fourth RUN cycle aborts the operation
    issue(8'h0F, 8'h0F, 1'b0);
    repeat (3) @(negedge iClk);
    iRst = 1'b1;
    #1;
    check("abort_busy", 32'(oBusy), 32'd0);
    check("abort_done", 32'(oDone), 32'd0);
    check("abort_sum", 32'({oCarry, oSum}), 32'd0);
    exp_q.delete();
    @(negedge iClk);
    iRst = 1'b0;
    repeat (W + 3) @(negedge iClk);
    run_op(8'h0F, 8'h0F, 1'b0, 1'b0);

    // iStart held high: a new operation every W+2 cycles
    @(negedge iClk);
    iA = 8'h80; iB = 8'h80; iSub = 1'b0; iStart = 1'b1;
    repeat (3) exp_q.push_back(ref_model(8'h80, 8'h80, 1'b0));
    for (int c = 1; c <= 40; c++) begin
      @(negedge iClk);
      if (c == 21) iStart = 1'b0;
      if (oDone) dones.push_back(c);
    end
    check("b2b_done_count", 32'(dones.size()), 32'd3);
    if (dones.size() == 3) begin
      check("b2b_first", 32'(dones[0]), 32'(W + 1));
      check("b2b_gap1", 32'(dones[1] - dones[0]), 32'(W + 2));
      check("b2b_gap2", 32'(dones[2] - dones[1]), 32'(W + 2));
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h20, 1'b1, 1'b0);
    run_op(8'h20, 8'h10, 1'b1, 1'b0);
`endif

    // randomized operations
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 6 == 0) ra = 8'hFF;
`ifdef SERIAL_ADDER_SUB_EN
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      run_op(ra, rb, 1'b0, 1'($urandom_range(0, 1)));
`endif
      repeat ($urandom_range(0, 2)) @(negedge iClk);
    end

    repeat (2) @(negedge iClk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
